// File: rtl/mem_port_arb_pkg.sv
// Shared types for the memory port arbiter: read-return owner tags and
// arbiter FSM states.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arb_tagpipe.sv
// Owner-tag delay line matching the memory read latency. A tag entered in
// the grant cycle appears on o_tag exactly DEPTH cycles later, which is the
// cycle the memory presents the read data. o_empty means no read is in flight.
module mem_port_arb_tagpipe
    import mem_port_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   i_clk,
    input  logic   i_reset,
    input  logic   i_push,
    input  owner_e i_tag,
    output owner_e o_tag,
    output logic   o_empty
);

    owner_e pipe_q [DEPTH];
    owner_e pipe_d [DEPTH];

    // Shift by one stage per cycle; idle cycles insert OWN_NONE
    always_comb begin
        pipe_d[0] = i_push ? i_tag : OWN_NONE;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipe registers; reset discards every in-flight read
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= OWN_NONE;
        end else begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    // Empty when no stage (including the one returning now) holds a read
    always_comb begin
        o_empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_q[i] != OWN_NONE) o_empty = 1'b0;
        end
    end

    assign o_tag = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store
// (LS). One access per cycle, combinational grant, fixed-latency read return
// routed by owner tag, and a RUN/DRAIN/HALTED sequence for clean core stop.
// Build option MEM_PORT_ARB_RR_EN: round-robin arbitration (last winner loses
// a tie, LS first after reset) instead of LS priority with IF starvation guard.
module mem_port_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_ls_req,
    input  logic                i_ls_we,
    input  logic [ADDR_W-1:0]   i_ls_addr,
    input  logic [DATA_W-1:0]   i_ls_wdata,
    input  logic [DATA_W/8-1:0] i_ls_bmask,
    output logic                o_ls_gnt,
    output logic                o_ls_rvalid,
    output logic [DATA_W-1:0]   o_ls_rdata,
    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_bmask,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    input  logic                i_halt_req,
    output logic                o_halted
);

    arb_state_e state_q, state_d;
    logic       grant_ok;
    logic       if_wins;
    logic       if_gnt, ls_gnt;
    logic       pipe_empty;
    owner_e     ret_tag;

`ifdef MEM_PORT_ARB_RR_EN
    logic last_ls_q, last_ls_d;

    // Tie goes to whichever requester did not win the previous grant
    always_comb begin
        if_wins = i_if_req & (~i_ls_req | last_ls_q);
    end

    // Remember the most recent winner; unchanged on idle cycles
    always_comb begin
        last_ls_d = last_ls_q;
        if (if_gnt | ls_gnt) last_ls_d = ls_gnt;
    end

    // Round-robin history; cleared so LS wins the first tie after reset
    always_ff @(posedge i_clk) begin
        if (i_reset) last_ls_q <= 1'b0;
        else         last_ls_q <= last_ls_d;
    end
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;

    // LS has priority unless IF has been denied STARVE_MAX cycles in a row
    always_comb begin
        if_wins = i_if_req & (~i_ls_req | (starve_cnt_q == SW'(STARVE_MAX)));
    end

    // Count consecutive IF denials, saturating; any IF grant or idle IF clears
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_if_req || if_gnt)                 starve_cnt_d = '0;
        else if (starve_cnt_q != SW'(STARVE_MAX)) starve_cnt_d = starve_cnt_q + SW'(1);
    end

    // Starvation counter register
    always_ff @(posedge i_clk) begin
        if (i_reset) starve_cnt_q <= '0;
        else         starve_cnt_q <= starve_cnt_d;
    end
`endif

    // Grants only in RUN (this includes the RUN->DRAIN cycle), never in reset
    always_comb begin
        grant_ok = (state_q == ST_RUN) & ~i_reset;
        if_gnt   = grant_ok & if_wins;
        ls_gnt   = grant_ok & i_ls_req & ~if_wins;
    end

    assign o_if_gnt = if_gnt;
    assign o_ls_gnt = ls_gnt;

    // Memory port mux: everything zero when idle, full mask on reads
    always_comb begin
        o_mem_en    = if_gnt | ls_gnt;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = '0;
        if (ls_gnt) begin
            o_mem_we    = i_ls_we;
            o_mem_addr  = i_ls_addr;
            o_mem_wdata = i_ls_we ? i_ls_wdata : '0;
            o_mem_bmask = i_ls_we ? i_ls_bmask : {(DATA_W/8){1'b1}};
        end else if (if_gnt) begin
            o_mem_addr  = i_if_addr;
            o_mem_bmask = {(DATA_W/8){1'b1}};
        end
    end

    mem_port_arb_tagpipe #(
        .DEPTH (MEM_LAT)
    ) u_tagpipe (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (if_gnt | (ls_gnt & ~i_ls_we)),
        .i_tag   (if_gnt ? OWN_IF : OWN_LS),
        .o_tag   (ret_tag),
        .o_empty (pipe_empty)
    );

    // Route returning data to its owner; data held at zero when not valid
    always_comb begin
        o_if_rvalid = ~i_reset & (ret_tag == OWN_IF);
        o_ls_rvalid = ~i_reset & (ret_tag == OWN_LS);
        o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
        o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;
    end

    // Halt sequencing; dropping the request always resumes RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (i_halt_req) state_d = ST_DRAIN;
            ST_DRAIN:  if (!i_halt_req)     state_d = ST_RUN;
                       else if (pipe_empty) state_d = ST_HALTED;
            ST_HALTED: if (!i_halt_req) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= ST_RUN;
        else         state_q <= state_d;
    end

    assign o_halted = (state_q == ST_HALTED) & ~i_reset;

endmodule
